// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that sits on the CPU data bus next to the RAM.
// A small TX FIFO is fed through a 4-word register window, and the bytes are shifted out LSB first on tx_o.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] CLKS_PER_BIT = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o
);
    localparam int               PTR_W = $clog2(FIFO_DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      divisor;
    logic [7:0]       shift;
    logic [15:0]      bit_len, bit_cnt;
    logic [2:0]       bit_idx;

    logic        sel, txdata_wr, status_wr, divisor_wr;
    logic        full, empty, push, pop, bit_done;
    logic [1:0]  offset;
    logic [31:0] rdata;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr[3:2];
    assign txdata_wr  = we && sel && (offset == 2'd0);
    assign status_wr  = we && sel && (offset == 2'd1);
    assign divisor_wr = we && sel && (offset == 2'd2);
    assign full       = (count == DEPTH);
    assign empty      = (count == '0);
    // Fullness is judged on the count at the start of the cycle, so a same-cycle pop never makes room.
    assign push       = txdata_wr && !full;
    assign pop        = (state == IDLE) && !empty;
    assign bit_done   = (bit_cnt == bit_len - 16'd1);

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        rdata = '0;
        case (offset)
            2'd1: begin
                rdata[0]    = (state != IDLE);
                rdata[1]    = full;
                rdata[2]    = empty;
                rdata[3]    = overflow;
                rdata[11:8] = 4'(count);
            end
            2'd2:    rdata[15:0] = divisor;
            default: rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divisor  <= CLKS_PER_BIT;
        end else begin
            data_o <= sel ? rdata : '0;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (txdata_wr && full)           overflow <= 1'b1;
            else if (status_wr && data_i[3]) overflow <= 1'b0;
            if (divisor_wr) divisor <= (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= data_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            shift   <= '0;
            bit_len <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_len <= divisor;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_o    <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        tx_o    <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx_o    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    tx_o  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register-access vector table plus hand-written serial frame sequences.
module tb_mmio_uart_tx;
    localparam logic [31:0] A_TX  = 32'h0001_0000;
    localparam logic [31:0] A_ST  = 32'h0001_0004;
    localparam logic [31:0] A_DIV = 32'h0001_0008;
    localparam logic [31:0] A_RSV = 32'h0001_000C;

    logic        clk, reset, we, tx_o;
    logic [31:0] addr, data_i, data_o;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t       vecs [17];
    logic [7:0] exp3 [5];

    mmio_uart_tx #(
        .BASE_ADDR   (32'h0001_0000),
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(16'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .data_i(data_i),
        .data_o(data_o),
        .tx_o  (tx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; data_i = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        we = 1'b0; addr = a;
        @(posedge clk); #1;
        d = data_o;
    endtask

    // Returns at the first falling-edge sample with tx_o low; w counts negedges stepped, so w==2 after
    // a frame means exactly one idle-high cycle.
    task automatic wait_start(input int budget, output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (tx_o !== 1'b0 && w < budget);
        check("start_seen", {31'd0, tx_o}, 32'd0);
    endtask

    // Called at the negedge holding the first start-bit sample; checks all 10*bl samples and decodes mid-bit.
    task automatic rx_frame(input int bl, input logic [7:0] exp_b, input string name);
        int         bad;
        logic       e;
        logic [7:0] got;
        bad = 0;
        got = '0;
        for (int k = 0; k < 10 * bl; k++) begin
            if (k > 0) @(negedge clk);
            if (k < bl)          e = 1'b0;
            else if (k < 9 * bl) e = exp_b[k / bl - 1];
            else                 e = 1'b1;
            if (tx_o !== e) bad++;
            if (k >= bl && k < 9 * bl && (k % bl) == bl / 2) got[k / bl - 1] = tx_o;
        end
        check({name, "_bits"}, bad, 0);
        check({name, "_byte"}, {24'd0, got}, {24'd0, exp_b});
    endtask

    initial begin
        logic [31:0] d;
        int          w, w3, n, lows;

        vecs[0]  = '{1'b0, A_ST,            32'h0,          32'h4};
        vecs[1]  = '{1'b0, A_DIV,           32'h0,          32'h10};
        vecs[2]  = '{1'b0, A_TX,            32'h0,          32'h0};
        vecs[3]  = '{1'b0, A_RSV,           32'h0,          32'h0};
        vecs[4]  = '{1'b1, 32'h0001_0010,   32'h77,         32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0000,   32'h88,         32'h0};
        vecs[6]  = '{1'b0, 32'h0001_0007,   32'h0,          32'h4};
        vecs[7]  = '{1'b1, A_DIV,           32'h0,          32'h10};
        vecs[8]  = '{1'b0, A_DIV,           32'h0,          32'h1};
        vecs[9]  = '{1'b1, A_RSV,           32'hFFFF,       32'h0};
        vecs[10] = '{1'b0, A_DIV,           32'h0,          32'h1};
        vecs[11] = '{1'b1, A_DIV,           32'h0001_2345,  32'h1};
        vecs[12] = '{1'b0, A_DIV,           32'h0,          32'h2345};
        vecs[13] = '{1'b1, A_ST,            32'hFFFF_FFFF,  32'h4};
        vecs[14] = '{1'b0, A_ST,            32'h0,          32'h4};
        vecs[15] = '{1'b0, 32'h0001_0005,   32'h0,          32'h4};
        vecs[16] = '{1'b0, A_RSV,           32'h0,          32'h0};
        exp3 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

        reset = 1'b1; we = 1'b0; addr = A_ST; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_o", data_o, 32'h0);
        check("reset_tx_o", {31'd0, tx_o}, 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            we = vecs[i].we; addr = vecs[i].addr; data_i = vecs[i].data;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), data_o, vecs[i].exp);
        end
        we = 1'b0;
        check("idle_tx_o", {31'd0, tx_o}, 32'd1);

        // 0x55 at divisor 4, with STATUS polled so the busy drop can be timed against the start bit.
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h55);
        wait_start(200, w);
        check("t2_start_latency", w, 2);
        fork
            rx_frame(4, 8'h55, "t2_frame");
            begin
                n = 0;
                do begin
                    bus_read(A_ST, d);
                    n++;
                end while (d[0] !== 1'b0 && n < 100);
                // data_o at the n-th edge reflects cycle n-1 after the start bit fell.
                check("t2_busy_clear", n, 41);
                check("t2_status_idle", d, 32'h4);
            end
        join

        // Five back-to-back bytes fill the FIFO, a sixth overflows, then overflow is cleared.
        bus_write(A_DIV, 32'd2);
        fork
            begin
                bus_write(A_TX, 32'hA1);
                bus_write(A_TX, 32'hB2);
                bus_write(A_TX, 32'hC3);
                bus_write(A_TX, 32'hD4);
                bus_write(A_TX, 32'hE5);
                bus_write(A_TX, 32'hF6);
                bus_read(A_ST, d);
                check("t3_status_full_ovf", d, 32'h40B);
                bus_write(A_ST, 32'h8);
                check("t3_status_on_clear", data_o, 32'h40B);
                bus_read(A_ST, d);
                check("t3_status_cleared", d, 32'h403);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    wait_start(300, w3);
                    if (i > 0) check($sformatf("t3_gap%0d", i), w3, 2);
                    rx_frame(2, exp3[i], $sformatf("t3_frame%0d", i));
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        bus_read(A_ST, d);
        check("t3_status_end", d, 32'h4);

        // Divisor 0 is stored as 1: two 10-cycle frames with one idle cycle between.
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, d);
        check("t5_div_zero", d, 32'h1);
        bus_write(A_TX, 32'h3C);
        bus_write(A_TX, 32'hC3);
        wait_start(200, w);
        rx_frame(1, 8'h3C, "t5_fast0");
        wait_start(200, w);
        check("t5_fast_gap", w, 2);
        rx_frame(1, 8'hC3, "t5_fast1");

        // Divisor change mid-frame only affects the following frame.
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h0F);
        bus_write(A_TX, 32'hF0);
        wait_start(200, w);
        fork
            rx_frame(4, 8'h0F, "t5_div4");
            begin
                repeat (10) @(posedge clk);
                #1;
                bus_write(A_DIV, 32'd8);
            end
        join
        wait_start(200, w);
        check("t5_div_gap", w, 2);
        rx_frame(8, 8'hF0, "t5_div8");
        bus_read(A_DIV, d);
        check("t5_div_read", d, 32'h8);

        // Reset during DATA bit 3 with two bytes queued, plus a write attempted while reset is high.
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h5A);
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        wait_start(200, w);
        repeat (17) @(negedge clk);
        reset = 1'b1; we = 1'b1; addr = A_TX; data_i = 32'h99;
        @(posedge clk); #1;
        check("t6_tx_reset", {31'd0, tx_o}, 32'd1);
        check("t6_data_o_reset", data_o, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; we = 1'b0;
        bus_read(A_ST, d);
        check("t6_status_after", d, 32'h4);
        bus_read(A_DIV, d);
        check("t6_div_after", d, 32'h10);
        lows = 0;
        repeat (120) begin
            @(negedge clk);
            if (tx_o !== 1'b1) lows++;
        end
        check("t6_no_frames", lows, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a bus responder on the CPU data-memory interface, alongside ram0.
- Uses the same port names as the RAM: we, addr, data_i, data_o.
- The CPU writes bytes into a small TX FIFO, and the block serialises them 8N1 on tx_o.
- data_o is zero when the block is not addressed, so the top level can OR it with the RAM read data.

Parameters:
- BASE_ADDR, 32'h0001_0000: byte address of the register window (4 words, 16 bytes, aligned).
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2, at least 2.
- CLKS_PER_BIT, 16: reset value of the DIVISOR register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable from the CPU, qualified by address decode.
- addr  in  32  byte address from the CPU.
- data_i  in  32  write data from the CPU.
- data_o  out  32  read data; registered; zero when not selected.
- tx_o  out  1  serial output; idles high.

Behaviour:
- Decode: sel = (addr[31:4] == BASE_ADDR[31:4]); offset = addr[3:2]; addr[1:0] ignored.
- Reads have no side effects. The CPU has no read strobe, so the bus is sampled every cycle.
- Register map:
  - offset 0 TXDATA: write pushes data_i[7:0] into the FIFO; reads return 0.
  - offset 1 STATUS (read):
    - bit0 busy: FSM not IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 overflow (sticky).
    - bits[11:8] FIFO count.
    - all other bits 0.
  - offset 1 STATUS (write): data_i[3]=1 clears overflow; other bits ignored.
  - offset 2 DIVISOR: R/W, 16 bits in data_i[15:0]. A written value of 0 is stored as 1. Reads are zero-extended.
  - offset 3: reserved; reads 0, writes ignored.
- Read latency: data_o is updated on the edge after addr is presented, using that cycle's addr. If sel was 0, data_o = 0.
- FIFO push:
  - On we && sel && offset==0, the push succeeds only if count < FIFO_DEPTH at the start of that cycle.
  - Otherwise the byte is dropped and overflow is set to 1.
  - A pop in the same cycle does not make room for the push.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH and needs log2(FIFO_DEPTH)+1 bits.
- A simultaneous push and pop leaves count unchanged, and both operations take effect.
- TX FSM states:
  - IDLE: tx_o=1. If the FIFO is not empty: pop the head byte into the shift register, latch DIVISOR into bit_len, clear the counters, go to START.
  - START: tx_o=0 for bit_len cycles, then go to DATA.
  - DATA: tx_o=shift[0], LSB first. After each bit_len cycles, shift right and increment bit_idx. After bit 7, go to STOP.
  - STOP: tx_o=1 for bit_len cycles, then go to IDLE.
- Frame timing:
  - The pop occurs in the cycle IDLE is left.
  - tx_o falls on the edge after a non-empty FIFO is seen in IDLE.
  - A frame is 10*bit_len cycles. Back-to-back frames have 1 idle-high cycle between the STOP bit and the next START bit.
- A DIVISOR write during a frame takes effect at the next frame only.
- Reset values:
  - data_o=0, tx_o=1, state IDLE.
  - FIFO empty, count=0, overflow=0.
  - DIVISOR=CLKS_PER_BIT; counters 0.
- Reset asserted mid-frame aborts the frame: tx_o=1 on the next edge and FIFO contents are discarded.
- Writes to the window while reset is high are ignored.

Test Plan:
1. After reset, read offset 1 → data_o=0x0000_0004 one cycle later (empty); tx_o=1. Read offset 2 → 16.
2. DIVISOR=4, write 0x55 to TXDATA → tx_o goes low the next edge for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high. Busy clears 40 cycles after the start bit; STATUS returns to 0x4.
3. DIVISOR=2, write 0xA1,0xB2,0xC3,0xD4,0xE5 in consecutive cycles:
   - 5 bytes are accepted: the first is popped the cycle after its write, leaving 4 in the FIFO, and no byte is lost.
   - A 6th write while full is dropped and STATUS bit3=1.
   - Writing STATUS with 0x8 clears overflow.
   - The serial stream decodes as A1 B2 C3 D4 E5, with 1 idle cycle between frames.
4. Address 0x0001_0010 and 0x0000_0000 (RAM) → writes are ignored, data_o=0, FIFO unchanged. Address 0x0001_0007 behaves as offset 1.
5. Write DIVISOR=0 → reads back 1, giving a 10-cycle frame. Changing DIVISOR from 4 to 8 mid-frame → the current frame stays at 40 cycles and the next is 80.
6. Assert reset during DATA bit 3 with 2 bytes queued → tx_o=1, STATUS=0x4 after release, and no further frames are sent.
